// File: rtl/si_frame_decoder_if.sv
// Byte-stream input handshake plus Simple Interface write port between the
// frame decoder (master) and the upstream source / register bank (slave).
`timescale 1ns/1ps
interface si_frame_decoder_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic [7:0]            rx_data;
    logic                  rx_rdy;
    logic                  rx_ack;
    logic [ADDR_WIDTH-1:0] register_addr;
    logic [DATA_WIDTH-1:0] register_data;
    logic                  register_rdy;
    logic                  register_ack;

    modport master (
        input  rx_data, rx_rdy, register_ack,
        output rx_ack, register_addr, register_data, register_rdy
    );

    modport slave (
        output rx_data, rx_rdy, register_ack,
        input  rx_ack, register_addr, register_data, register_rdy
    );
endinterface

// File: rtl/si_frame_decoder.sv
// Turns an upstream byte stream (address byte + DATA_WIDTH/8 data bytes, MSB
// first) into single Simple Interface writes toward the config register bank.
//
// state   | meaning
// S_ADDR  | idle, waiting for the address byte of a new frame
// S_DATA  | collecting data bytes, byte-gap timer running
// S_WRITE | register_rdy held high, waiting for register_ack or ack timeout
`timescale 1ns/1ps
module si_frame_decoder #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 8,
    parameter int BYTE_TIMEOUT = 1000,
    parameter int ACK_TIMEOUT  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    si_frame_decoder_if.master      bus,
    output logic                    busy,
    output logic                    frame_error,
    output logic                    ack_timeout
);
    localparam int NB   = DATA_WIDTH / 8;
    localparam int CW   = $clog2(NB + 1);
    localparam int TMAX = (BYTE_TIMEOUT > ACK_TIMEOUT) ? BYTE_TIMEOUT : ACK_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {S_ADDR, S_DATA, S_WRITE} state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [CW-1:0] byte_cnt;
    logic          accept;

    // rx_ack still high means the byte on rx_data was already consumed
    assign accept = bus.rx_rdy && !bus.rx_ack && ((state == S_ADDR) || (state == S_DATA));

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= S_ADDR;
            timer             <= '0;
            byte_cnt          <= '0;
            bus.rx_ack        <= 1'b0;
            bus.register_addr <= '0;
            bus.register_data <= '0;
            bus.register_rdy  <= 1'b0;
            busy              <= 1'b0;
            frame_error       <= 1'b0;
            ack_timeout       <= 1'b0;
        end else begin
            bus.rx_ack  <= accept;
            frame_error <= 1'b0;
            ack_timeout <= 1'b0;
            case (state)
                S_ADDR: begin
                    if (accept) begin
                        bus.register_addr <= bus.rx_data[ADDR_WIDTH-1:0];
                        bus.register_data <= '0;
                        byte_cnt          <= '0;
                        timer             <= TW'(BYTE_TIMEOUT - 1);
                        state             <= S_DATA;
                        busy              <= 1'b1;
                    end
                end
                S_DATA: begin
                    // a byte arriving in the expiry cycle wins and restarts the gap timer
                    if (accept) begin
                        bus.register_data <= DATA_WIDTH'({bus.register_data, bus.rx_data});
                        timer             <= TW'(BYTE_TIMEOUT - 1);
                        if (byte_cnt == CW'(NB - 1)) begin
                            byte_cnt         <= '0;
                            timer            <= TW'(ACK_TIMEOUT - 1);
                            bus.register_rdy <= 1'b1;
                            state            <= S_WRITE;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end else if (timer == '0) begin
                        frame_error <= 1'b1;
                        byte_cnt    <= '0;
                        state       <= S_ADDR;
                        busy        <= 1'b0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_WRITE: begin
                    if (bus.register_ack) begin
                        bus.register_rdy <= 1'b0;
                        timer            <= '0;
                        state            <= S_ADDR;
                        busy             <= 1'b0;
                    end else if (timer == '0) begin
                        ack_timeout      <= 1'b1;
                        bus.register_rdy <= 1'b0;
                        state            <= S_ADDR;
                        busy             <= 1'b0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    bus.register_rdy <= 1'b0;
                    state            <= S_ADDR;
                    busy             <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_si_frame_decoder.sv
// Scoreboard bench for si_frame_decoder: frames are described at transaction
// level, expected writes are queued, and a monitor checks what the DUT emits.
`timescale 1ns/1ps
module tb_si_frame_decoder;
    localparam int AW      = 7;
    localparam int DW      = 16;
    localparam int NB      = DW / 8;
    localparam int BYTE_TO = 20;
    localparam int ACK_TO  = 16;

    typedef struct {
        int addr;
        int data;
        int len;
        bit to;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic busy, frame_error, ack_timeout;
    logic resp_ack  = 1'b0;
    logic stray_ack = 1'b0;

    exp_t exp_q[$];
    int   dly_q[$];
    int   checks = 0, errors = 0;
    int   exp_ferr = 0, exp_ato = 0, exp_racks = 0;
    int   ferr_seen = 0, ato_seen = 0, racks_seen = 0;
    bit   in_reset_test = 1'b0;

    si_frame_decoder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    assign bus.register_ack = resp_ack | stray_ack;

    si_frame_decoder #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_TIMEOUT(BYTE_TO), .ACK_TIMEOUT(ACK_TO)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .busy(busy), .frame_error(frame_error), .ack_timeout(ack_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rdy"}, bus.register_rdy, 0);
        check({tag, "_rx_ack"}, bus.rx_ack, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_frame_error"}, frame_error, 0);
        check({tag, "_ack_timeout"}, ack_timeout, 0);
        check({tag, "_addr"}, bus.register_addr, 0);
        check({tag, "_data"}, bus.register_data, 0);
    endtask

    // Reference: a write holds rdy d+1 cycles if acked d cycles in, else ACK_TO then times out
    task automatic push_exp(input int addr, input int data, input int d);
        exp_t e;
        e.addr = addr % (1 << AW);
        e.data = data;
        e.to   = (d >= ACK_TO);
        e.len  = e.to ? ACK_TO : d + 1;
        if (e.to) exp_ato++;
        exp_q.push_back(e);
        dly_q.push_back(d);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        bus.rx_data = b;
        bus.rx_rdy  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.rx_ack && n < 100);
        check("rx_ack_wait", bus.rx_ack, 1);
        if (bus.rx_ack) exp_racks++;
        bus.rx_rdy = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_bytes(input int addr, input int data, input int nbytes, input int gapmax);
        send_byte(8'(addr), $urandom_range(0, gapmax));
        for (int i = 0; i < nbytes; i++)
            send_byte(8'(data >> (8 * (NB - 1 - i))), $urandom_range(0, gapmax));
    endtask

    task automatic send_frame(input int addr, input int data, input int d);
        push_exp(addr, data, d);
        send_bytes(addr, data, NB, 8);
    endtask

    task automatic send_partial(input int addr, input int k);
        int n;
        exp_ferr++;
        send_bytes(addr, $urandom, k, 8);
        n = 0;
        while (busy && n < BYTE_TO + 10) begin
            @(negedge clk);
            n++;
        end
        check("partial_busy_drop", busy, 0);
    endtask

    task automatic wait_quiet();
        int n;
        n = 0;
        while ((busy || bus.register_rdy || exp_q.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("quiet_busy", busy, 0);
        repeat (3) @(negedge clk);
    endtask

    function automatic int pick_delay();
        int r;
        r = $urandom_range(0, 9);
        if (r <= 5) return r;
        if (r == 6) return ACK_TO - 1;
        if (r == 7) return ACK_TO;
        return ACK_TO + 3;
    endfunction

    // Register-bank responder
    initial begin
        int d;
        int n;
        forever begin
            @(negedge clk);
            if (bus.register_rdy && !rst) begin
                if (dly_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL responder_queue actual=empty required=pending_write");
                    d = ACK_TO + 1;
                end else begin
                    d = dly_q.pop_front();
                end
                if (d < ACK_TO) begin
                    repeat (d) @(negedge clk);
                    resp_ack = 1'b1;
                    @(negedge clk);
                    resp_ack = 1'b0;
                end else begin
                    n = 0;
                    while (bus.register_rdy && n < 200) begin
                        @(negedge clk);
                        n++;
                    end
                end
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        exp_t cur;
        int   len;
        int   since;
        bit   prev_rdy, prev_rack;
        cur = '{0, 0, 0, 1'b0};
        len = 0; since = 0; prev_rdy = 1'b0; prev_rack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_rdy  = 1'b0;
                prev_rack = 1'b0;
            end else begin
                if (bus.rx_ack) begin
                    racks_seen++;
                    check("rx_ack_one_cycle", prev_rack, 0);
                    since = 0;
                end else begin
                    since++;
                end
                if (bus.register_rdy && !prev_rdy) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write actual=addr_0x%0h required=none", bus.register_addr);
                    end else begin
                        cur = exp_q.pop_front();
                        check("write_addr", bus.register_addr, cur.addr);
                        check("write_data", bus.register_data, cur.data);
                        check("rdy_with_final_rx_ack", bus.rx_ack, 1);
                    end
                    len = 1;
                end else if (bus.register_rdy) begin
                    len++;
                    check("backpressure_rx_ack", bus.rx_ack, 0);
                    check("addr_stable", bus.register_addr, cur.addr);
                    check("data_stable", bus.register_data, cur.data);
                end else if (prev_rdy && !in_reset_test) begin
                    check("rdy_length", len, cur.len);
                    check("ack_timeout_pulse", ack_timeout, cur.to);
                end
                if (frame_error) begin
                    ferr_seen++;
                    check("frame_error_busy", busy, 0);
                    check("frame_error_delay", since, BYTE_TO);
                end
                if (ack_timeout) ato_seen++;
                prev_rdy  = bus.register_rdy;
                prev_rack = bus.rx_ack;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst         = 1'b1;
        bus.rx_rdy  = 1'b0;
        bus.rx_data = 8'h00;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Stray ack while idle must be ignored
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        @(negedge clk);
        check("stray_ack_busy", busy, 0);
        check("stray_ack_rdy", bus.register_rdy, 0);
        check("stray_ack_timeout", ack_timeout, 0);

        send_frame(8'h10, 16'h1234, 2);
        send_partial(8'h07, 0);
        send_frame(8'h08, 16'h55AA, 1);
        send_frame(8'h9C, 16'hBEEF, ACK_TO);
        send_frame(8'h21, 16'h0F0F, ACK_TO - 1);
        send_partial(8'h44, 1);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0)
                send_partial($urandom_range(0, 255), $urandom_range(0, NB - 1));
            else
                send_frame($urandom_range(0, 255), $urandom_range(0, 65535), pick_delay());
        end
        wait_quiet();

        // Reset while a write is pending; the bank never acks this one
        begin
            exp_t e;
            e.addr = 8'h33 % (1 << AW);
            e.data = 16'hDEAD;
            e.len  = 0;
            e.to   = 1'b0;
            exp_q.push_back(e);
            dly_q.push_back(ACK_TO + 50);
        end
        send_bytes(8'h33, 16'hDEAD, NB, 2);
        n = 0;
        while (!bus.register_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("reset_test_rdy_seen", bus.register_rdy, 1);
        repeat (3) @(negedge clk);
        in_reset_test = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midwrite_reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        in_reset_test = 1'b0;
        send_frame(8'h01, 16'h00FF, 1);
        wait_quiet();

        check("exp_queue_drained", exp_q.size(), 0);
        check("frame_error_count", ferr_seen, exp_ferr);
        check("ack_timeout_count", ato_seen, exp_ato);
        check("rx_ack_count", racks_seen, exp_racks);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
